// File: rtl/hsid_x_read_sched.sv
// HSID-X read scheduler: issues one OBI burst for the captured pixel, then one
// burst per library pixel, and raises done plus a sticky interrupt at the end.
module hsid_x_read_sched #(
    parameter int WORD_WIDTH       = 32,
    parameter int HSI_BANDS        = 254,
    parameter int HSI_LIBRARY_SIZE = 4095,
    localparam int HSI_BANDS_ADDR        = $clog2(HSI_BANDS),
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             clear,
    input  logic [HSI_BANDS_ADDR-1:0]        pixel_bands,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
    input  logic [WORD_WIDTH-1:0]            captured_pixel_addr,
    input  logic [WORD_WIDTH-1:0]            library_pixel_addr,
    input  logic                             obi_done,
    output logic                             obi_start,
    output logic [WORD_WIDTH-1:0]            obi_initial_addr,
    output logic [HSI_BANDS_ADDR-1:0]        obi_limit,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] pixel_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             int_o
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CAPT_START = 3'd1;
    localparam logic [2:0] CAPT_WAIT  = 3'd2;
    localparam logic [2:0] LIB_START  = 3'd3;
    localparam logic [2:0] LIB_WAIT   = 3'd4;
    localparam logic [2:0] FINISH     = 3'd5;

    logic [2:0]                       state;
    logic [HSI_BANDS_ADDR-1:0]        words_q;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] last_idx_q;
    logic [WORD_WIDTH-1:0]            lib_addr_q;
    logic [WORD_WIDTH-1:0]            cur_addr;

    logic [HSI_BANDS_ADDR:0]          bands_p1;
    logic [HSI_BANDS_ADDR-1:0]        words_in;
    logic [WORD_WIDTH-1:0]            stride;
    logic [WORD_WIDTH-1:0]            next_addr;

    // Two 16-bit bands per bus word; an odd band count rounds up.
    always_comb begin
        bands_p1  = {1'b0, pixel_bands} + 1'b1;
        words_in  = bands_p1[HSI_BANDS_ADDR:1];
        stride    = WORD_WIDTH'(words_q) << 2;
        next_addr = cur_addr + stride;
    end

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            words_q          <= '0;
            last_idx_q       <= '0;
            lib_addr_q       <= '0;
            cur_addr         <= '0;
            obi_start        <= 1'b0;
            obi_initial_addr <= '0;
            obi_limit        <= '0;
            pixel_idx        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            int_o            <= 1'b0;
        end else begin
            obi_start <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            if (clear) begin
                state            <= IDLE;
                busy             <= 1'b0;
                pixel_idx        <= '0;
                int_o            <= 1'b0;
                obi_initial_addr <= '0;
                obi_limit        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (pixel_bands != '0 && library_size != '0) begin
                                words_q          <= words_in;
                                last_idx_q       <= library_size - 1'b1;
                                lib_addr_q       <= library_pixel_addr;
                                obi_initial_addr <= captured_pixel_addr;
                                obi_limit        <= words_in;
                                obi_start        <= 1'b1;
                                busy             <= 1'b1;
                                int_o            <= 1'b0;
                                state            <= CAPT_START;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    CAPT_START: state <= CAPT_WAIT;
                    CAPT_WAIT: begin
                        if (obi_done) begin
                            pixel_idx        <= '0;
                            cur_addr         <= lib_addr_q;
                            obi_initial_addr <= lib_addr_q;
                            obi_start        <= 1'b1;
                            state            <= LIB_START;
                        end
                    end
                    LIB_START: state <= LIB_WAIT;
                    LIB_WAIT: begin
                        if (obi_done) begin
                            if (pixel_idx == last_idx_q) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                pixel_idx        <= pixel_idx + 1'b1;
                                cur_addr         <= next_addr;
                                obi_initial_addr <= next_addr;
                                obi_start        <= 1'b1;
                                state            <= LIB_START;
                            end
                        end
                    end
                    FINISH: begin
                        int_o            <= 1'b1;
                        busy             <= 1'b0;
                        obi_initial_addr <= '0;
                        obi_limit        <= '0;
                        state            <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hsid_x_read_sched.md
Name: hsid_x_read_sched

Overview:
Read scheduler for the HSID-X accelerator. It sits between the control register block and the OBI memory reader. On a start command it runs two phases. First it reads the captured pixel as one OBI burst. Then it reads each library pixel as its own burst, advancing the library address per pixel. It raises a done pulse and a sticky interrupt when the whole library has been read.

Parameters:
WORD_WIDTH, 32, bus word and address width in bits
HSI_BANDS, 254, maximum number of bands per pixel
HSI_LIBRARY_SIZE, 4095, maximum number of library pixels
HSI_BANDS_ADDR, $clog2(HSI_BANDS), localparam: width of band count and burst length
HSI_LIBRARY_SIZE_ADDR, $clog2(HSI_LIBRARY_SIZE), localparam: width of library count and index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start command, 1-cycle pulse from control registers
clear  in  1  abort operation and clear interrupt
pixel_bands  in  HSI_BANDS_ADDR  bands per pixel
library_size  in  HSI_LIBRARY_SIZE_ADDR  number of library pixels
captured_pixel_addr  in  WORD_WIDTH  byte address of the captured pixel
library_pixel_addr  in  WORD_WIDTH  byte address of library pixel 0
obi_done  in  1  burst-complete pulse from the OBI reader
obi_start  out  1  burst start pulse to the OBI reader
obi_initial_addr  out  WORD_WIDTH  burst byte address
obi_limit  out  HSI_BANDS_ADDR  burst length in words
pixel_idx  out  HSI_LIBRARY_SIZE_ADDR  index of the library pixel currently being read
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse when the library read completes
error  out  1  1-cycle pulse when start is rejected
int_o  out  1  sticky completion interrupt

Behaviour:
- Clock and reset: single clock clk, rising edge. Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; every output 0; all internal latches 0.
- Registered outputs: all outputs are registered, with no combinational path from input to output.
- FSM states: IDLE, CAPT_START, CAPT_WAIT, LIB_START, LIB_WAIT, FINISH.
- IDLE, start=1 with pixel_bands!=0 and library_size!=0:
  - latch both addresses and library_size;
  - words = (pixel_bands+1)>>1, two 16-bit bands per word, odd band count rounds up;
  - go to CAPT_START.
- IDLE, start=1 with pixel_bands==0 or library_size==0: error=1 for 1 cycle; stay in IDLE; no burst is issued.
- CAPT_START: obi_start=1 for exactly 1 cycle; obi_initial_addr=latched captured address; obi_limit=words; go to CAPT_WAIT.
- CAPT_WAIT: on obi_done, set pixel_idx=0 and cur_addr=latched library address, then go to LIB_START.
- LIB_START: obi_start=1 for 1 cycle; obi_initial_addr=cur_addr; obi_limit=words; go to LIB_WAIT.
- LIB_WAIT, on obi_done:
  - if pixel_idx==library_size-1, go to FINISH;
  - otherwise pixel_idx+=1, cur_addr+=words*4, go to LIB_START.
- FINISH: done=1 for 1 cycle; int_o<=1; go to IDLE.
- Output stability: obi_initial_addr and obi_limit hold stable from each *_START state until the next *_START state. Both read 0 in IDLE.
- Latency:
  - obi_start rises exactly 1 cycle after the start pulse is accepted;
  - each following burst starts 1 cycle after the obi_done that ends the previous burst;
  - done rises 1 cycle after the final obi_done.
- Address arithmetic: cur_addr is a WORD_WIDTH-bit byte address and wraps modulo 2^WORD_WIDTH with no error. words*4 is computed at WORD_WIDTH width.
- start outside IDLE: ignored. No re-latch, no error.
- obi_done outside CAPT_WAIT and LIB_WAIT: ignored.
- clear in any state:
  - next state is IDLE;
  - obi_start, done, pixel_idx and int_o go to 0 next cycle;
  - an in-flight burst is abandoned, and its later obi_done is ignored.
- clear and start in the same cycle: clear wins; no burst and no error.
- int_o: set in FINISH. Cleared by clear or by the next accepted start; stays 1 until then.
- Config changes mid-operation: changes to pixel_bands, library_size or the address inputs after start has been accepted have no effect until the next start.
- Reset mid-operation: asynchronous return to the reset values. No stray obi_start after rst_n is released.

Test Plan:
- bands=4, lib=3, capt=0x1000, lib_addr=0x2000, reader answers obi_done 5 cycles after each obi_start → four obi_start pulses with addresses 0x1000, 0x2000, 0x2008, 0x2010, all with limit=2; pixel_idx steps 0,1,2; done 1 cycle after the 4th obi_done; int_o=1 and busy=0 afterwards.
- bands=5, lib=2, lib_addr=0x3000 → limit=3; library addresses 0x3000 and 0x300C.
- lib=0, or bands=0, then start → error pulse of exactly 1 cycle; obi_start never asserts; busy stays 0.
- clear during LIB_WAIT of pixel 1 in the lib=3 run → IDLE next cycle; no done; int_o=0; pixel_idx=0; a late obi_done produces no new obi_start.
- Second start pulse during CAPT_WAIT, and start+clear together in IDLE → both have no effect: no error, no extra burst.
- lib_addr=0xFFFFFFF8, bands=4, lib=3 → library addresses wrap to 0xFFFFFFF8, 0x00000000, 0x00000008. Separately, rst_n low in LIB_WAIT → all outputs 0 immediately.
